// File: rtl/seg_display_driver.sv
// Scans a 32-bit value (ledData or PCOut) onto eight multiplexed active-low hex digits; an/seg registered, one cycle behind scan state.
// Optional halt blink via SEG_HALT_BLINK_EN; no flow control, inputs are sampled only at each scan end.
module seg_display_driver #(
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_SCANS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ledData,
    input  logic [31:0] PCOut,
    input  logic        halt,
    input  logic        sel,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       digit;
    logic [31:0]      shadow;
    logic             tick;
    logic             scan_end;
    logic             blank;

    assign tick     = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign scan_end = tick && (digit == 3'd7);
    assign dp       = 1'b1;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The shadow only reloads at scan end so one scan never mixes two source values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            digit   <= '0;
            shadow  <= '0;
            an      <= 8'hFF;
            seg     <= 7'h7F;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                digit <= digit + 3'd1;
            if (scan_end)
                shadow <= sel ? PCOut : ledData;
            an  <= blank ? 8'hFF : ~(8'h01 << digit);
            seg <= hex_to_seg(shadow[{digit, 2'b00} +: 4]);
        end
    end

`ifdef SEG_HALT_BLINK_EN
    localparam int SCAN_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    logic [SCAN_W-1:0] scan_cnt;
    logic              phase;

    // Blink state only lives while halted; dropping halt relights on the very next edge.
    always_ff @(posedge clk) begin
        if (rst || !halt) begin
            scan_cnt <= '0;
            phase    <= 1'b0;
        end else if (scan_end) begin
            if (scan_cnt == SCAN_W'(BLINK_SCANS - 1)) begin
                scan_cnt <= '0;
                phase    <= ~phase;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    assign blank = halt && phase;
`else
    logic unused_halt;
    assign unused_halt = halt;
    assign blank       = 1'b0;
`endif

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with SCAN_DIV=4, BLINK_SCANS=2; outputs sampled on the falling edge.
module tb_seg_display_driver;
    localparam int SCAN_DIV    = 4;
    localparam int BLINK_SCANS = 2;
    localparam int SCAN_CYC    = 8 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ledData = '0;
    logic [31:0] PCOut = '0;
    logic        halt = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int asserts  = 0;
    int failures = 0;

    seg_display_driver #(
        .SCAN_DIV(SCAN_DIV),
        .BLINK_SCANS(BLINK_SCANS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ledData(ledData),
        .PCOut(PCOut),
        .halt(halt),
        .sel(sel),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        asserts++;
        assert ($countones(~an) <= 1)
        else begin
            failures++;
            $display("FAIL onehot: an=%h has more than one enabled digit", an);
        end
    end

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        ledData = 32'h89ABCDEF;
        sel     = 1'b0;
        repeat (3) step();
        asserts++;
        if (an !== 8'hFF) begin failures++; $display("FAIL reset_an: got %h want ff", an); end
        asserts++;
        if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %h want 7f", seg); end
        asserts++;
        if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b want 1", dp); end
        rst = 1'b0;
    endtask

    // First scan after reset shows zeros even though ledData is already non-zero.
    task automatic test_first_scan();
        logic [7:0] ea;
        for (int i = 0; i < SCAN_CYC; i++) begin
            step();
            ea = ~(8'h01 << (i / SCAN_DIV));
            asserts++;
            if (an !== ea) begin failures++; $display("FAIL first_scan_an[%0d]: got %h want %h", i, an, ea); end
            asserts++;
            if (seg !== 7'h40) begin failures++; $display("FAIL first_scan_seg[%0d]: got %h want 40", i, seg); end
        end
    endtask

    task automatic test_led_data();
        logic [31:0] v;
        logic [7:0]  ea;
        logic [6:0]  es;
        v = 32'h89ABCDEF;
        for (int i = 0; i < SCAN_CYC; i++) begin
            step();
            ea = ~(8'h01 << (i / SCAN_DIV));
            es = enc(v[(i / SCAN_DIV) * 4 +: 4]);
            asserts++;
            if (an !== ea) begin failures++; $display("FAIL led_an[%0d]: got %h want %h", i, an, ea); end
            asserts++;
            if (seg !== es) begin failures++; $display("FAIL led_seg[%0d]: got %h want %h", i, seg, es); end
        end
    endtask

    task automatic test_sel_switch();
        logic [31:0] v;
        logic [7:0]  ea;
        logic [6:0]  es;
        v = 32'h89ABCDEF;
        for (int i = 0; i < SCAN_CYC; i++) begin
            if (i == 10) begin
                sel     = 1'b1;
                PCOut   = 32'h00000400;
                ledData = 32'h0;
            end
            step();
            es = enc(v[(i / SCAN_DIV) * 4 +: 4]);
            asserts++;
            if (seg !== es) begin failures++; $display("FAIL sel_same_scan[%0d]: got %h want %h", i, seg, es); end
        end
        for (int i = 0; i < SCAN_CYC; i++) begin
            step();
            ea = ~(8'h01 << (i / SCAN_DIV));
            es = ((i / SCAN_DIV) == 2) ? 7'h19 : 7'h40;
            asserts++;
            if (an !== ea) begin failures++; $display("FAIL sel_an[%0d]: got %h want %h", i, an, ea); end
            asserts++;
            if (seg !== es) begin failures++; $display("FAIL sel_next_scan[%0d]: got %h want %h", i, seg, es); end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] ea;
        sel     = 1'b0;
        ledData = 32'hFFFFFFFF;
        repeat (21) step();
        asserts++;
        if (an !== 8'hDF) begin failures++; $display("FAIL mid_digit5: got %h want df", an); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        asserts++;
        if (an !== 8'hFF) begin failures++; $display("FAIL mid_rst_an: got %h want ff", an); end
        asserts++;
        if (seg !== 7'h7F) begin failures++; $display("FAIL mid_rst_seg: got %h want 7f", seg); end
        for (int i = 0; i < SCAN_CYC; i++) begin
            if (i == 3) ledData = 32'h12345678;
            step();
            ea = ~(8'h01 << (i / SCAN_DIV));
            asserts++;
            if (an !== ea) begin failures++; $display("FAIL post_rst_an[%0d]: got %h want %h", i, an, ea); end
            asserts++;
            if (seg !== 7'h40) begin failures++; $display("FAIL post_rst_seg[%0d]: got %h want 40", i, seg); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic [6:0]  es;
        v = 32'h12345678;
        for (int i = 0; i < SCAN_CYC; i++) begin
            if (i == 5) ledData = 32'hA5A5A5A5;
            step();
            es = enc(v[(i / SCAN_DIV) * 4 +: 4]);
            asserts++;
            if (seg !== es) begin failures++; $display("FAIL b2b_seg_a[%0d]: got %h want %h", i, seg, es); end
        end
        v = 32'hA5A5A5A5;
        for (int i = 0; i < SCAN_CYC; i++) begin
            step();
            es = enc(v[(i / SCAN_DIV) * 4 +: 4]);
            asserts++;
            if (seg !== es) begin failures++; $display("FAIL b2b_seg_b[%0d]: got %h want %h", i, seg, es); end
        end
    endtask

`ifdef SEG_HALT_BLINK_EN
    task automatic test_halt_blink();
        logic [7:0] ea;
        halt = 1'b1;
        for (int i = 0; i < 2 * SCAN_CYC; i++) begin
            step();
            ea = ~(8'h01 << ((i % SCAN_CYC) / SCAN_DIV));
            asserts++;
            if (an !== ea) begin failures++; $display("FAIL blink_lit1[%0d]: got %h want %h", i, an, ea); end
        end
        for (int i = 0; i < 2 * SCAN_CYC; i++) begin
            step();
            asserts++;
            if (an !== 8'hFF) begin failures++; $display("FAIL blink_dark[%0d]: got %h want ff", i, an); end
        end
        for (int i = 0; i < 2 * SCAN_CYC; i++) begin
            step();
            ea = ~(8'h01 << ((i % SCAN_CYC) / SCAN_DIV));
            asserts++;
            if (an !== ea) begin failures++; $display("FAIL blink_lit2[%0d]: got %h want %h", i, an, ea); end
        end
        for (int i = 0; i < 10; i++) begin
            step();
            asserts++;
            if (an !== 8'hFF) begin failures++; $display("FAIL blink_dark2[%0d]: got %h want ff", i, an); end
        end
        halt = 1'b0;
        step();
        asserts++;
        if (an !== 8'hFB) begin failures++; $display("FAIL blink_release: got %h want fb", an); end
    endtask
`else
    task automatic test_halt_ignored();
        logic [7:0] ea;
        halt = 1'b1;
        for (int i = 0; i < 4 * SCAN_CYC; i++) begin
            step();
            ea = ~(8'h01 << ((i % SCAN_CYC) / SCAN_DIV));
            asserts++;
            if (an !== ea) begin failures++; $display("FAIL halt_ignored[%0d]: got %h want %h", i, an, ea); end
        end
        halt = 1'b0;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_first_scan();
        test_led_data();
        test_sel_switch();
        test_reset_mid_scan();
        test_back_to_back();
`ifdef SEG_HALT_BLINK_EN
        test_halt_blink();
`else
        test_halt_ignored();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
